// File: rtl/acc_sched_pkg.sv
// Shared types for the accumulator scheduler: FSM state encoding and
// small helpers used by the top level and the round-robin arbiter.
package acc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    localparam int DoneCountWidth = 16;

    // Wrapping successor of a requester index for non power-of-two counts.
    function automatic int wrap_index(input int base, input int offset, input int count);
        return (base + offset) % count;
    endfunction

endpackage

// File: rtl/acc_scheduler_if.sv
// Handshake bundle between requesters, the shared accumulator, the result
// consumer and the scheduler; master is the scheduler side.
interface acc_scheduler_if #(
    parameter int DataWidth   = 32,
    parameter int NumReq      = 4,
    parameter int NumReqWidth = 2
);

    logic [NumReq-1:0]           ReqValid;
    logic [NumReq*DataWidth-1:0] ReqData;
    logic [NumReq-1:0]           ReqRdy;

    logic                        AccInValid;
    logic [DataWidth-1:0]        AccInData;
    logic                        AccInRdy;
    logic                        AccOutValid;
    logic [DataWidth-1:0]        AccOutData;
    logic                        AccClr;

    logic                        ResValid;
    logic [DataWidth-1:0]        ResData;
    logic [NumReqWidth-1:0]      ResId;
    logic                        ResRdy;

    modport master (
        input  ReqValid, ReqData, AccInRdy, AccOutValid, AccOutData, ResRdy,
        output ReqRdy, AccInValid, AccInData, AccClr, ResValid, ResData, ResId
    );

    modport slave (
        output ReqValid, ReqData, AccInRdy, AccOutValid, AccOutData, ResRdy,
        input  ReqRdy, AccInValid, AccInData, AccClr, ResValid, ResData, ResId
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first valid requester
// searching upward from LastGrant+1 and wrapping.
module rr_arbiter
    import acc_sched_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int NumReqWidth = 2
) (
    input  logic [NumReq-1:0]      ReqValid,
    input  logic [NumReqWidth-1:0] LastGrant,
    output logic                   AnyReq,
    output logic [NumReqWidth-1:0] NextGrant
);

    logic [NumReqWidth-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        AnyReq    = |ReqValid;
        NextGrant = LastGrant;
        cand      = '0;
        for (int i = NumReq; i >= 1; i--) begin
            cand = NumReqWidth'(wrap_index(int'(LastGrant), i, NumReq));
            if (ReqValid[cand]) begin
                NextGrant = cand;
            end
        end
    end

endmodule

// File: rtl/acc_scheduler.sv
// Time-shares one accumulator among NumReq requesters in bursts of
// AccumulateCount samples. Optional DoneCount output under ACC_SCHED_STATS_EN.
module acc_scheduler
    import acc_sched_pkg::*;
#(
    parameter int DataWidth            = 32,
    parameter int NumReq               = 4,
    parameter int NumReqWidth          = 2,
    parameter int AccumulateCount      = 2,
    parameter int AccumulateCountWidth = 1
) (
    input  logic             clk,
    input  logic             sclr,
    acc_scheduler_if.master  bus
`ifdef ACC_SCHED_STATS_EN
    ,
    output logic [DoneCountWidth-1:0] DoneCount
`endif
);

    localparam logic [AccumulateCountWidth-1:0] LastSample =
        AccumulateCountWidth'(AccumulateCount - 1);

    sched_state_t                    state;
    logic [NumReqWidth-1:0]          grant;
    logic [NumReqWidth-1:0]          last_grant;
    logic [AccumulateCountWidth-1:0] sample_cnt;
    logic                            res_valid;
    logic [DataWidth-1:0]            res_data;
    logic [NumReqWidth-1:0]          res_id;
    logic                            acc_clr;

    logic                            any_req;
    logic [NumReqWidth-1:0]          next_grant;
    logic                            sample_xfer;
    logic [DataWidth-1:0]            req_lane [NumReq];

    for (genvar r = 0; r < NumReq; r++) begin : g_lane
        assign req_lane[r] = bus.ReqData[r*DataWidth +: DataWidth];
    end

    rr_arbiter #(
        .NumReq      (NumReq),
        .NumReqWidth (NumReqWidth)
    ) u_arb (
        .ReqValid  (bus.ReqValid),
        .LastGrant (last_grant),
        .AnyReq    (any_req),
        .NextGrant (next_grant)
    );

    // Only the granted requester sees the accumulator; everyone else is stalled.
    always_comb begin
        bus.ReqRdy     = '0;
        bus.AccInValid = 1'b0;
        bus.AccInData  = '0;
        if (state == GRANT) begin
            bus.AccInValid    = bus.ReqValid[grant];
            bus.AccInData     = req_lane[grant];
            bus.ReqRdy[grant] = bus.AccInRdy;
        end
    end

    assign sample_xfer = (state == GRANT) && bus.AccInValid && bus.AccInRdy;

    // A dropped ReqValid mid-burst simply stalls in GRANT; the grant is held.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= IDLE;
            sample_cnt <= '0;
            grant      <= '0;
            last_grant <= NumReqWidth'(NumReq - 1);
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            acc_clr    <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (sample_xfer) begin
                        if (sample_cnt == LastSample) begin
                            sample_cnt <= '0;
                            state      <= WAIT;
                        end else begin
                            sample_cnt <= sample_cnt + AccumulateCountWidth'(1);
                        end
                    end
                end
                WAIT: begin
                    if (bus.AccOutValid) begin
                        res_data  <= bus.AccOutData;
                        res_id    <= grant;
                        res_valid <= 1'b1;
                        acc_clr   <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_valid && bus.ResRdy) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ResValid = res_valid;
    assign bus.ResData  = res_data;
    assign bus.ResId    = res_id;
    assign bus.AccClr   = acc_clr;

`ifdef ACC_SCHED_STATS_EN
    logic [DoneCountWidth-1:0] done_count;

    always_ff @(posedge clk) begin
        if (sclr) begin
            done_count <= '0;
        end else if (state == RESULT && res_valid && bus.ResRdy) begin
            done_count <= done_count + DoneCountWidth'(1);
        end
    end

    assign DoneCount = done_count;
`endif

endmodule

// File: doc/acc_scheduler.md
ACC_SCHEDULER -- requirements
Module: acc_scheduler

Interface
REQ-001 Parameters SHALL be: DataWidth, 32, operand and result width; NumReq, 4, number of requesters; NumReqWidth, 2, requester index width; AccumulateCount, 2, samples per burst; AccumulateCountWidth, 1, sample counter width.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 sclr  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 ReqValid  input  NumReq  per-requester sample valid.
REQ-005 ReqData  input  NumReq*DataWidth  requester r's sample in bits [r*DataWidth +: DataWidth].
REQ-006 ReqRdy  output  NumReq  per-requester ready; a sample transfers when ReqValid[r] and ReqRdy[r] are both high.
REQ-007 AccInValid  output  1  sample valid to the shared accumulator.
REQ-008 AccInData  output  DataWidth  sample to the shared accumulator.
REQ-009 AccInRdy  input  1  accumulator ready.
REQ-010 AccOutValid  input  1  accumulator one-cycle result pulse.
REQ-011 AccOutData  input  DataWidth  accumulator result.
REQ-012 AccClr  output  1  clear pulse to the accumulator.
REQ-013 ResValid  output  1  result valid, held until accepted.
REQ-014 ResData  output  DataWidth  burst result.
REQ-015 ResId  output  NumReqWidth  index of the requester that owns ResData.
REQ-016 ResRdy  input  1  result consumer ready.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT, WAIT and RESULT.
REQ-018 IDLE: if any ReqValid is high, the block SHALL register Grant by round-robin starting at LastGrant+1 (mod NumReq), update LastGrant, and move to GRANT; otherwise it stays in IDLE.
REQ-019 GRANT: the block SHALL drive AccInValid=ReqValid[Grant], AccInData=ReqData[Grant] and ReqRdy[Grant]=AccInRdy; all other ReqRdy bits are 0.
REQ-020 In GRANT, each cycle with AccInValid and AccInRdy both high SHALL increment SampleCnt; the handshake that makes SampleCnt reach AccumulateCount SHALL move the FSM to WAIT and clear SampleCnt.
REQ-021 Outside GRANT, AccInValid and every ReqRdy bit SHALL be 0.
REQ-022 If ReqValid[Grant] drops in the middle of a burst, the grant SHALL be held, and the block SHALL wait with no re-arbitration.
REQ-023 WAIT: on AccOutValid the block SHALL capture ResData=AccOutData and ResId=Grant, set ResValid=1, and move to RESULT; AccOutValid in any other state SHALL be ignored.
REQ-024 AccClr SHALL be registered and SHALL be high for exactly the first cycle spent in RESULT.
REQ-025 RESULT: ResValid, ResData and ResId SHALL stay stable until ResValid and ResRdy are both high; on that cycle ResValid SHALL clear and the FSM SHALL go to IDLE.
REQ-026 The minimum turnaround SHALL be one cycle in IDLE between bursts. No new grant SHALL be issued while a result is pending.

Reset
REQ-027 With sclr high, on the next edge the FSM SHALL be IDLE, SampleCnt=0, Grant=0, LastGrant=NumReq-1 (requester 0 has first priority), ResValid=0, ResData=0, ResId=0, AccClr=0.
REQ-028 An sclr in the middle of a burst SHALL abandon the burst with no result. The accumulator is reset by its own reset.

Configuration
REQ-029 With ACC_SCHED_STATS_EN defined, the block SHALL add output DoneCount (16 bits, reset 0). DoneCount increments on each ResValid and ResRdy handshake and wraps from 0xFFFF to 0.
REQ-030 With ACC_SCHED_STATS_EN undefined, DoneCount SHALL be absent and there SHALL be no other change to behaviour.

Structure
REQ-031 The FSM state encoding typedef and the state constants SHALL be in a shared package, acc_sched_pkg.
REQ-032 The round-robin selector SHALL be a sub-module, rr_arbiter, that is combinational from (ReqValid, LastGrant) to (AnyReq, NextGrant).

Verification
REQ-033 Reset, then ReqValid=0001 with ReqData[0]=1.0, 2.0, and AccOutValid=1 with AccOutData=3.0 in WAIT -> ResValid=1, ResData=3.0 (0x40400000), ResId=0, with AccClr high for exactly 1 cycle.
REQ-034 ReqValid=1111 held for 4 bursts -> grants in order 0,1,2,3 and ResId sequence 0,1,2,3.
REQ-035 AccInRdy toggles 1,0,0,1 during GRANT -> exactly 2 samples are transferred, and ReqRdy of the non-granted requesters stays 0 throughout.
REQ-036 ResRdy held at 0 for 5 cycles in RESULT -> ResValid/ResData/ResId are stable, and no ReqRdy asserts until the handshake.
REQ-037 sclr asserted after 1 of 2 samples -> next cycle is IDLE with ResValid=0; a new request from requester 2 alone gets Grant=2.
REQ-038 With ACC_SCHED_STATS_EN defined, 3 completed bursts -> DoneCount=3; when preloaded to 0xFFFF, one burst -> DoneCount=0.
